core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
- Multi-cycle control FSM for the single-issue core; sits between instruction fetch, decoder, ALU and LSU.
- Fetches one instruction at a time and holds it stable for the decoder.
- Drives the decoder's cycle counter, gates register-file writes, and owns the PC.
- Handles taken branches, jumps, LSU waits, illegal-instruction traps, and counts retired instructions.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded on reset
TRAP_ADDR, 32'h0000_0100, PC loaded on any trap
ADDR_WIDTH, 32, PC/fetch address width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-high
fetch_req_o  output  1  fetch request, high for the whole FETCH state
fetch_addr_o  output  ADDR_WIDTH  fetch address (= pc)
fetch_valid_i  input  1  instruction returned; sampled only in FETCH
fetch_instr_i  input  32  returned instruction word
instr_o  output  32  latched instruction to decoder
instr_addr_o  output  ADDR_WIDTH  address of instr_o
cycle_counter_o  output  1  decoder cycle: 0 in EXEC0, 1 in EXEC1
jump_inst_i, branch_inst_i, illegal_inst_i, compressed_inst_i  input  1 each  decoder flags
lsu_r_en_i, lsu_w_en_i, rf_we_i  input  1 each  decoder LSU/RF enables
alu_result_i  input  32  bit0 = branch compare result (EXEC0); next-PC target (EXEC1)
lsu_req_o  output  1  one-cycle LSU start pulse
lsu_done_i  input  1  LSU access complete
rf_we_o  output  1  gated register-file write enable
trap_o  output  1  one-cycle trap pulse
trap_pc_o  output  ADDR_WIDTH  address of faulting instruction, valid while trap_o is high
instret_o  output  32  retired-instruction counter

Behaviour:
- States: BOOT, FETCH, EXEC0, EXEC1, MEM_WAIT, TRAP.
- Reset (async, rst=1):
  - state=BOOT, pc=RESET_ADDR, instr_q=32'h0000_0013 (NOP), instret=0.
  - All pulse/enable outputs are 0; trap_pc_o=0.
- BOOT: one cycle, then FETCH.
- FETCH:
  - fetch_req_o=1.
  - On fetch_valid_i: latch instr_q and iaddr_q=pc, then go to EXEC0.
  - Otherwise stay in FETCH.
- EXEC0 (cycle_counter_o=0); decoder outputs are valid this cycle. Priority order:
  1. illegal_inst_i -> TRAP.
  2. lsu_r_en_i|lsu_w_en_i -> lsu_req_o=1 this cycle, go to MEM_WAIT; rf_we_o=0.
  3. jump_inst_i -> rf_we_o=rf_we_i (link = pc+inc), go to EXEC1.
  4. branch_inst_i:
     - alu_result_i[0]=1 -> EXEC1.
     - Otherwise pc+=inc, retire, go to FETCH.
  5. Else -> rf_we_o=rf_we_i, pc+=inc, retire, go to FETCH.
  - inc is 2 if compressed_inst_i, else 4.
- EXEC1 (cycle_counter_o=1):
  - rf_we_o=0.
  - target = alu_result_i with bit0 cleared.
  - Misaligned target (see Optional Feature) -> TRAP.
  - Otherwise pc=target, retire, go to FETCH.
- MEM_WAIT:
  - lsu_req_o=0; wait for lsu_done_i.
  - In the done cycle: rf_we_o=rf_we_i (loads only), pc+=inc, retire, go to FETCH.
  - lsu_done_i asserted during EXEC0 is ignored.
- TRAP:
  - trap_o=1, trap_pc_o=iaddr_q.
  - pc=TRAP_ADDR; no retire; go to FETCH.
- Retire: instret+=1, wrapping 32'hFFFF_FFFF -> 0.
- fetch_valid_i outside FETCH is ignored.
- Reset mid-operation (any state, including MEM_WAIT with a request outstanding) aborts immediately; the LSU response after reset is ignored.
- Latency:
  - ALU op: FETCH + 1 cycle.
  - Jump or taken branch: FETCH + 2 cycles.
  - Load/store: FETCH + 1 + LSU wait cycles.

Optional Feature:
- Macro: RISCV_RVC_EN.
- Defined:
  - Compressed instructions execute with inc=2.
  - A target is misaligned only if bit0 is set (cannot occur after clearing).
- Undefined:
  - compressed_inst_i in EXEC0 is treated as illegal (-> TRAP).
  - EXEC1 target with bit1=1 -> TRAP, trap_pc_o = jump/branch address.
  - inc is always 4.

Decomposition:
- Package riscv_defines gains:
  - seq_state_t enum (BOOT, FETCH, EXEC0, EXEC1, MEM_WAIT, TRAP).
  - PC_INC_32=4 and PC_INC_16=2.
  - NOP_INSTR=32'h0000_0013.
- One sub-module, pc_reg: PC register plus next-PC mux (hold/inc/target/trap/reset), with an async active-high reset to RESET_ADDR.

Test Plan:
- Reset release, then ADDI 32'h0050_0093 returned at 0x0:
  - fetch_req_o goes high 1 cycle after BOOT.
  - EXEC0 lasts 1 cycle with rf_we_o=1.
  - Afterwards pc=0x4, instret=1.
- BEQ at 0x10 with alu_result_i=1 in EXEC0, then 0x40 in EXEC1:
  - cycle_counter_o goes 0 then 1.
  - pc=0x40, rf_we_o=0 throughout.
  - Same branch with alu_result_i=0 -> pc=0x14.
- JALR returning target 0x103:
  - With RISCV_RVC_EN: pc=0x102.
  - Without: trap_o pulse, pc=TRAP_ADDR 0x100, instret unchanged.
- Load, lsu_done_i held low 3 cycles:
  - lsu_req_o is a single pulse.
  - rf_we_o=1 only in the done cycle.
  - pc advances by 4.
- illegal_inst_i at 0x20:
  - trap_o high 1 cycle with trap_pc_o=0x20.
  - Next fetch_addr_o=0x100.
- rst asserted mid-MEM_WAIT:
  - Outputs drop immediately, pc=0x0.
  - Late lsu_done_i is ignored and instret=0.

Source files
------------

// File: rtl/core_sequencer_pkg.sv
// Shared sequencer types and constants for the single-issue core.
// Compressed-instruction support is selected by the RISCV_RVC_EN macro.
package riscv_defines;

  typedef enum logic [2:0] {
    BOOT,
    FETCH,
    EXEC0,
    EXEC1,
    MEM_WAIT,
    TRAP
  } seq_state_t;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_TARGET,
    PC_TRAP,
    PC_RESET
  } pc_sel_t;

  localparam logic [2:0]  PC_INC_32 = 3'd4;
  localparam logic [2:0]  PC_INC_16 = 3'd2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

`ifdef RISCV_RVC_EN
  localparam bit RVC_EN = 1'b1;
`else
  localparam bit RVC_EN = 1'b0;
`endif

  // Sequential PC step for the instruction currently in EXEC0.
  function automatic logic [2:0] pc_step(input logic compressed);
    return (RVC_EN && compressed) ? PC_INC_16 : PC_INC_32;
  endfunction

endpackage

// File: rtl/core_sequencer_pc_reg.sv
// Program counter with next-PC select (hold / increment / target / trap / reset).
module pc_reg
  import riscv_defines::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_ADDR  = ADDR_WIDTH'(32'h0000_0100)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            i_sel,
  input  logic [2:0]            i_inc,
  input  logic [ADDR_WIDTH-1:0] i_target,
  output logic [ADDR_WIDTH-1:0] o_pc
);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_nxt;

  always_comb begin
    w_pc_nxt = r_pc;
    case (i_sel)
      PC_INC:    w_pc_nxt = r_pc + ADDR_WIDTH'(i_inc);
      PC_TARGET: w_pc_nxt = i_target;
      PC_TRAP:   w_pc_nxt = TRAP_ADDR;
      PC_RESET:  w_pc_nxt = RESET_ADDR;
      default:   w_pc_nxt = r_pc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_ADDR;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns PC, gates RF writes, starts LSU, raises traps.
// RISCV_RVC_EN enables 16-bit instructions; without it they trap, as do targets with bit1 set.
module core_sequencer
  import riscv_defines::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(32'h0000_0000),
  parameter logic [ADDR_WIDTH-1:0] TRAP_ADDR  = ADDR_WIDTH'(32'h0000_0100)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fetch_req_o,
  output logic [ADDR_WIDTH-1:0] fetch_addr_o,
  input  logic                  fetch_valid_i,
  input  logic [31:0]           fetch_instr_i,
  output logic [31:0]           instr_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  cycle_counter_o,
  input  logic                  jump_inst_i,
  input  logic                  branch_inst_i,
  input  logic                  illegal_inst_i,
  input  logic                  compressed_inst_i,
  input  logic                  lsu_r_en_i,
  input  logic                  lsu_w_en_i,
  input  logic                  rf_we_i,
  input  logic [31:0]           alu_result_i,
  output logic                  lsu_req_o,
  input  logic                  lsu_done_i,
  output logic                  rf_we_o,
  output logic                  trap_o,
  output logic [ADDR_WIDTH-1:0] trap_pc_o,
  output logic [31:0]           instret_o
);

  seq_state_t            r_state;
  logic [31:0]           r_instr;
  logic [ADDR_WIDTH-1:0] r_iaddr;
  logic [2:0]            r_inc;
  logic [31:0]           r_instret;

  logic [ADDR_WIDTH-1:0] w_pc;
  logic [ADDR_WIDTH-1:0] w_target;
  logic [2:0]            w_inc;
  logic [2:0]            w_pc_inc;
  logic                  w_illegal;
  logic                  w_mem;
  logic                  w_redirect;
  logic                  w_misaligned;
  logic                  w_retire;
  logic                  w_rf_we;
  logic                  w_lsu_req;
  pc_sel_t               w_pc_sel;

  assign w_target   = ADDR_WIDTH'(alu_result_i & 32'hFFFF_FFFE);
  assign w_inc      = pc_step(compressed_inst_i);
  assign w_mem      = lsu_r_en_i | lsu_w_en_i;
  assign w_redirect = jump_inst_i | (branch_inst_i & alu_result_i[0]);

`ifdef RISCV_RVC_EN
  assign w_illegal    = illegal_inst_i;
  assign w_misaligned = w_target[0];
`else
  assign w_illegal    = illegal_inst_i | compressed_inst_i;
  assign w_misaligned = w_target[1];
`endif

  // The step is captured in EXEC0 so MEM_WAIT does not rely on decoder flags later.
  assign w_pc_inc = (r_state == EXEC0) ? w_inc : r_inc;

  always_comb begin
    w_pc_sel  = PC_HOLD;
    w_retire  = 1'b0;
    w_rf_we   = 1'b0;
    w_lsu_req = 1'b0;
    case (r_state)
      EXEC0: begin
        if (w_illegal) begin
          w_pc_sel = PC_HOLD;
        end else if (w_mem) begin
          w_lsu_req = 1'b1;
        end else if (jump_inst_i) begin
          w_rf_we = rf_we_i;
        end else if (branch_inst_i) begin
          if (!alu_result_i[0]) begin
            w_pc_sel = PC_INC;
            w_retire = 1'b1;
          end
        end else begin
          w_rf_we  = rf_we_i;
          w_pc_sel = PC_INC;
          w_retire = 1'b1;
        end
      end
      EXEC1: begin
        if (!w_misaligned) begin
          w_pc_sel = PC_TARGET;
          w_retire = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (lsu_done_i) begin
          w_rf_we  = rf_we_i & lsu_r_en_i;
          w_pc_sel = PC_INC;
          w_retire = 1'b1;
        end
      end
      TRAP: begin
        w_pc_sel = PC_TRAP;
      end
      default: begin
        w_pc_sel = PC_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= BOOT;
      r_instr   <= NOP_INSTR;
      r_iaddr   <= '0;
      r_inc     <= PC_INC_32;
      r_instret <= '0;
    end else begin
      if (w_retire) begin
        r_instret <= r_instret + 32'd1;
      end
      case (r_state)
        BOOT: begin
          r_state <= FETCH;
        end
        FETCH: begin
          if (fetch_valid_i) begin
            r_instr <= fetch_instr_i;
            r_iaddr <= w_pc;
            r_state <= EXEC0;
          end
        end
        EXEC0: begin
          r_inc <= w_inc;
          if (w_illegal) begin
            r_state <= TRAP;
          end else if (w_mem) begin
            r_state <= MEM_WAIT;
          end else if (w_redirect) begin
            r_state <= EXEC1;
          end else begin
            r_state <= FETCH;
          end
        end
        EXEC1: begin
          r_state <= w_misaligned ? TRAP : FETCH;
        end
        MEM_WAIT: begin
          if (lsu_done_i) begin
            r_state <= FETCH;
          end
        end
        TRAP: begin
          r_state <= FETCH;
        end
        default: begin
          r_state <= BOOT;
        end
      endcase
    end
  end

  pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_ADDR (RESET_ADDR),
    .TRAP_ADDR  (TRAP_ADDR)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .i_sel    (w_pc_sel),
    .i_inc    (w_pc_inc),
    .i_target (w_target),
    .o_pc     (w_pc)
  );

  assign fetch_req_o     = (r_state == FETCH);
  assign fetch_addr_o    = w_pc;
  assign instr_o         = r_instr;
  assign instr_addr_o    = r_iaddr;
  assign cycle_counter_o = (r_state == EXEC1);
  assign lsu_req_o       = w_lsu_req;
  assign rf_we_o         = w_rf_we;
  assign trap_o          = (r_state == TRAP);
  assign trap_pc_o       = trap_o ? r_iaddr : '0;
  assign instret_o       = r_instret;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: directed instruction table, random instruction stream vs reference model,
// and hand-written reset sequences. Honours RISCV_RVC_EN the same way as the design.
module tb_core_sequencer;

`ifdef RISCV_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif
  localparam logic [31:0] TRAP_PC = 32'h0000_0100;

  localparam logic [7:0] F_ILL = 8'h01, F_LD = 8'h02, F_ST = 8'h04, F_JMP = 8'h08;
  localparam logic [7:0] F_BR  = 8'h10, F_CMP = 8'h20, F_RF = 8'h40, F_TKN = 8'h80;

  typedef struct {
    logic [31:0] instr;
    bit ill, ld, st, jmp, br, comp, rf, taken;
    logic [31:0] target;
    int wt;
    int fdly;
  } vec_t;

  typedef struct {
    logic [31:0] npc;
    int cyc;
    int trap;
    int ret;
    int rfwe;
    int rfwe_idx;
    int lsu;
    logic [7:0] cc;
  } exp_t;

  typedef struct {
    vec_t v;
    exp_t e;
  } row_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_valid_i;
  logic [31:0] fetch_instr_i;
  logic [31:0] instr_o;
  logic [31:0] instr_addr_o;
  logic        cycle_counter_o;
  logic        jump_inst_i, branch_inst_i, illegal_inst_i, compressed_inst_i;
  logic        lsu_r_en_i, lsu_w_en_i, rf_we_i;
  logic [31:0] alu_result_i;
  logic        lsu_req_o;
  logic        lsu_done_i;
  logic        rf_we_o;
  logic        trap_o;
  logic [31:0] trap_pc_o;
  logic [31:0] instret_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;
  row_t rows[$];

  always #5 clk = ~clk;

  core_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .fetch_req_o       (fetch_req_o),
    .fetch_addr_o      (fetch_addr_o),
    .fetch_valid_i     (fetch_valid_i),
    .fetch_instr_i     (fetch_instr_i),
    .instr_o           (instr_o),
    .instr_addr_o      (instr_addr_o),
    .cycle_counter_o   (cycle_counter_o),
    .jump_inst_i       (jump_inst_i),
    .branch_inst_i     (branch_inst_i),
    .illegal_inst_i    (illegal_inst_i),
    .compressed_inst_i (compressed_inst_i),
    .lsu_r_en_i        (lsu_r_en_i),
    .lsu_w_en_i        (lsu_w_en_i),
    .rf_we_i           (rf_we_i),
    .alu_result_i      (alu_result_i),
    .lsu_req_o         (lsu_req_o),
    .lsu_done_i        (lsu_done_i),
    .rf_we_o           (rf_we_o),
    .trap_o            (trap_o),
    .trap_pc_o         (trap_pc_o),
    .instret_o         (instret_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic vec_t mkv(logic [31:0] instr, logic [7:0] f, logic [31:0] tgt, int wt);
    vec_t v;
    v.instr = instr;
    v.ill = f[0]; v.ld = f[1]; v.st = f[2]; v.jmp = f[3];
    v.br = f[4]; v.comp = f[5]; v.rf = f[6]; v.taken = f[7];
    v.target = tgt;
    v.wt = wt;
    v.fdly = 0;
    return v;
  endfunction

  function automatic exp_t mke(logic [31:0] npc, int cyc, int trap, int ret,
                               int rfwe, int rfwe_idx, int lsu, logic [7:0] cc);
    exp_t e;
    e.npc = npc; e.cyc = cyc; e.trap = trap; e.ret = ret;
    e.rfwe = rfwe; e.rfwe_idx = rfwe_idx; e.lsu = lsu; e.cc = cc;
    return e;
  endfunction

  // Reference model: outcome of one instruction from the architectural rules.
  function automatic exp_t model(vec_t v, logic [31:0] pc);
    exp_t e;
    logic [31:0] tgt;
    logic [31:0] inc;
    bit illegal;
    e = mke(pc, 1, 0, 0, 0, -1, 0, 8'h00);
    illegal = v.ill || (v.comp && !RVC);
    inc = (RVC && v.comp) ? 32'd2 : 32'd4;
    tgt = v.target & 32'hFFFF_FFFE;
    if (illegal) begin
      e.cyc = 2; e.trap = 1; e.npc = TRAP_PC;
    end else if (v.ld || v.st) begin
      e.cyc = v.wt + 2; e.lsu = 1; e.ret = 1; e.npc = pc + inc;
      if (v.ld && v.rf) begin e.rfwe = 1; e.rfwe_idx = v.wt + 1; end
    end else if (v.jmp || (v.br && v.taken)) begin
      e.cc = 8'h02;
      if (v.jmp && v.rf) begin e.rfwe = 1; e.rfwe_idx = 0; end
      if (!RVC && tgt[1]) begin
        e.cyc = 3; e.trap = 1; e.npc = TRAP_PC;
      end else begin
        e.cyc = 2; e.ret = 1; e.npc = tgt;
      end
    end else begin
      e.ret = 1; e.npc = pc + inc;
      if (!v.br && v.rf) begin e.rfwe = 1; e.rfwe_idx = 0; end
    end
    return e;
  endfunction

  task automatic run(input vec_t v, input exp_t e, input string tag);
    int n, idx, rfwe, rfidx, lsu, trap, bad_instr;
    logic [31:0] tpc, addr;
    logic [7:0] cc;
    bit done;
    n = 0; idx = 0; rfwe = 0; rfidx = -1; lsu = 0; trap = 0; bad_instr = 0;
    tpc = '0; cc = '0; done = 0;
    while (!fetch_req_o && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, ".fetch_req"}, {31'b0, fetch_req_o}, 32'd1);
    chk({tag, ".fetch_addr"}, fetch_addr_o, exp_pc);
    addr = fetch_addr_o;
    repeat (v.fdly) begin
      @(negedge clk); #1;
    end
    fetch_valid_i = 1'b1;
    fetch_instr_i = v.instr;
    while (!done) begin
      @(negedge clk);
      illegal_inst_i    = v.ill;
      lsu_r_en_i        = v.ld;
      lsu_w_en_i        = v.st;
      jump_inst_i       = v.jmp;
      branch_inst_i     = v.br;
      compressed_inst_i = v.comp;
      rf_we_i           = v.rf;
      alu_result_i      = (idx == 0) ? {31'b0, v.taken} : v.target;
      lsu_done_i        = (v.ld || v.st) && (idx == 0 || idx == 1 + v.wt);
      fetch_valid_i     = 1'b1;
      fetch_instr_i     = ~v.instr;
      #1;
      if (fetch_req_o) begin
        fetch_valid_i = 1'b0;
        lsu_done_i    = 1'b0;
        done = 1;
      end else begin
        if (idx < 8) cc[idx] = cycle_counter_o;
        if (rf_we_o) begin rfwe++; rfidx = idx; end
        if (lsu_req_o) lsu++;
        if (trap_o) begin trap++; tpc = trap_pc_o; end
        if (instr_o !== v.instr) bad_instr++;
        idx++;
        if (idx > 30) begin
          fetch_valid_i = 1'b0;
          lsu_done_i    = 1'b0;
          done = 1;
        end
      end
    end
    chk({tag, ".cycles"}, idx, e.cyc);
    chk({tag, ".trap_cnt"}, trap, e.trap);
    if (e.trap != 0) chk({tag, ".trap_pc"}, tpc, addr);
    chk({tag, ".next_pc"}, fetch_addr_o, e.npc);
    exp_ret = exp_ret + e.ret;
    chk({tag, ".instret"}, instret_o, exp_ret);
    chk({tag, ".rf_we_cnt"}, rfwe, e.rfwe);
    if (e.rfwe != 0) chk({tag, ".rf_we_cycle"}, rfidx, e.rfwe_idx);
    chk({tag, ".lsu_req_cnt"}, lsu, e.lsu);
    chk({tag, ".cycle_counter"}, {24'b0, cc}, {24'b0, e.cc});
    chk({tag, ".instr_stable"}, bad_instr, 0);
    chk({tag, ".instr_o"}, instr_o, v.instr);
    chk({tag, ".instr_addr"}, instr_addr_o, addr);
    exp_pc = e.npc;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    exp_t e;
    int n, r;

    rows.push_back('{mkv(32'h0050_0093, F_RF, 32'h0, 0), mke(32'h04, 1, 0, 1, 1, 0, 0, 8'h00)});
    rows.push_back('{mkv(32'h0020_81B3, F_RF, 32'h0, 0), mke(32'h08, 1, 0, 1, 1, 0, 0, 8'h00)});
    rows.push_back('{mkv(32'h0080_00EF, F_JMP | F_RF, 32'h10, 0), mke(32'h10, 2, 0, 1, 1, 0, 0, 8'h02)});
    rows.push_back('{mkv(32'h0200_0863, F_BR | F_TKN, 32'h40, 0), mke(32'h40, 2, 0, 1, 0, -1, 0, 8'h02)});
    rows.push_back('{mkv(32'hFD1F_F06F, F_JMP, 32'h11, 0), mke(32'h10, 2, 0, 1, 0, -1, 0, 8'h02)});
    rows.push_back('{mkv(32'h0200_0863, F_BR | F_RF, 32'h40, 0), mke(32'h14, 1, 0, 1, 0, -1, 0, 8'h00)});
    rows.push_back('{mkv(32'h0000_A103, F_LD | F_RF, 32'h0, 3), mke(32'h18, 5, 0, 1, 1, 4, 1, 8'h00)});
    rows.push_back('{mkv(32'h0020_A023, F_ST, 32'h0, 0), mke(32'h1C, 2, 0, 1, 0, -1, 1, 8'h00)});
    rows.push_back('{mkv(32'h0040_006F, F_JMP, 32'h20, 0), mke(32'h20, 2, 0, 1, 0, -1, 0, 8'h02)});
    rows.push_back('{mkv(32'hFFFF_FFFF, F_ILL, 32'h0, 0), mke(32'h100, 2, 1, 0, 0, -1, 0, 8'h00)});
`ifdef RISCV_RVC_EN
    rows.push_back('{mkv(32'h0000_80E7, F_JMP | F_RF, 32'h103, 0), mke(32'h102, 2, 0, 1, 1, 0, 0, 8'h02)});
    rows.push_back('{mkv(32'h0000_0505, F_CMP | F_RF, 32'h0, 0), mke(32'h104, 1, 0, 1, 1, 0, 0, 8'h00)});
`else
    rows.push_back('{mkv(32'h0000_80E7, F_JMP | F_RF, 32'h103, 0), mke(32'h100, 3, 1, 0, 1, 0, 0, 8'h02)});
    rows.push_back('{mkv(32'h0000_0505, F_CMP | F_RF, 32'h0, 0), mke(32'h100, 2, 1, 0, 0, -1, 0, 8'h00)});
`endif
    rows.push_back('{mkv(32'h0000_A103, F_ILL | F_LD | F_RF, 32'h0, 0), mke(32'h100, 2, 1, 0, 0, -1, 0, 8'h00)});
    rows.push_back('{mkv(32'h0000_A183, F_LD | F_JMP | F_RF, 32'h40, 1), mke(32'h104, 3, 0, 1, 1, 2, 1, 8'h00)});

    rst = 1'b1;
    fetch_valid_i = 1'b0; fetch_instr_i = '0;
    jump_inst_i = 1'b0; branch_inst_i = 1'b0; illegal_inst_i = 1'b0; compressed_inst_i = 1'b0;
    lsu_r_en_i = 1'b0; lsu_w_en_i = 1'b0; rf_we_i = 1'b0; alu_result_i = '0; lsu_done_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.fetch_req", {31'b0, fetch_req_o}, 32'd0);
    chk("reset.lsu_req", {31'b0, lsu_req_o}, 32'd0);
    chk("reset.rf_we", {31'b0, rf_we_o}, 32'd0);
    chk("reset.trap", {31'b0, trap_o}, 32'd0);
    chk("reset.trap_pc", trap_pc_o, 32'd0);
    chk("reset.instret", instret_o, 32'd0);
    chk("reset.fetch_addr", fetch_addr_o, 32'd0);
    chk("reset.instr_nop", instr_o, 32'h0000_0013);
    chk("reset.cycle_counter", {31'b0, cycle_counter_o}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("boot.fetch_req", {31'b0, fetch_req_o}, 32'd0);
    @(negedge clk);
    #1;
    chk("boot.fetch_after_1", {31'b0, fetch_req_o}, 32'd1);

    exp_pc = 32'h0;
    exp_ret = 32'h0;
    for (int i = 0; i < rows.size(); i++) begin
      run(rows[i].v, rows[i].e, $sformatf("dir%0d", i));
    end

    for (int i = 0; i < 200; i++) begin
      v = mkv($urandom, 8'h00, $urandom & 32'h0000_0FFF, int'($urandom_range(0, 4)));
      v.fdly = int'($urandom_range(0, 2));
      r = int'($urandom_range(0, 99));
      v.rf    = 1'($urandom_range(0, 1));
      v.taken = 1'($urandom_range(0, 1));
      v.comp  = ($urandom_range(0, 4) == 0);
      if (r < 8) v.ill = 1'b1;
      else if (r < 25) v.ld = 1'b1;
      else if (r < 35) v.st = 1'b1;
      else if (r < 50) v.jmp = 1'b1;
      else if (r < 70) v.br = 1'b1;
      if ($urandom_range(0, 9) == 0) v.jmp = 1'b1;
      e = model(v, exp_pc);
      run(v, e, $sformatf("rnd%0d", i));
    end

    // Reset while a load is waiting on the LSU; the late response must be dropped.
    n = 0;
    while (!fetch_req_o && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("rstmem.pre_instret_nonzero", {31'b0, (instret_o != 32'd0)}, 32'd1);
    fetch_valid_i = 1'b1;
    fetch_instr_i = 32'h0000_A103;
    @(negedge clk);
    fetch_valid_i = 1'b0;
    illegal_inst_i = 1'b0; jump_inst_i = 1'b0; branch_inst_i = 1'b0; compressed_inst_i = 1'b0;
    lsu_w_en_i = 1'b0; lsu_r_en_i = 1'b1; rf_we_i = 1'b1; lsu_done_i = 1'b0;
    #1;
    chk("rstmem.lsu_req", {31'b0, lsu_req_o}, 32'd1);
    @(negedge clk);
    #1;
    chk("rstmem.wait_lsu_req", {31'b0, lsu_req_o}, 32'd0);
    chk("rstmem.wait_rf_we", {31'b0, rf_we_o}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rstmem.fetch_req", {31'b0, fetch_req_o}, 32'd0);
    chk("rstmem.pc", fetch_addr_o, 32'd0);
    chk("rstmem.instret", instret_o, 32'd0);
    chk("rstmem.instr_nop", instr_o, 32'h0000_0013);
    @(negedge clk);
    rst = 1'b0;
    lsu_done_i = 1'b1;
    #1;
    chk("rstmem.late_done_rf_we", {31'b0, rf_we_o}, 32'd0);
    @(negedge clk);
    #1;
    chk("rstmem.refetch", {31'b0, fetch_req_o}, 32'd1);
    chk("rstmem.refetch_addr", fetch_addr_o, 32'd0);
    chk("rstmem.late_done_instret", instret_o, 32'd0);
    lsu_done_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
